// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared widths, FSM state encoding and defaults for the memory arbiter
package tinyalu_pkg;
  localparam int NUM_REQ     = 4;
  localparam int MEM_ADDR_W  = 14;
  localparam int MEM_WDATA_W = 16;
  localparam int MEM_RDATA_W = 8;
  localparam int ARB_TIMEOUT = 16;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t S_IDLE  = 2'd0;
  localparam arb_state_t S_ISSUE = 2'd1;
  localparam arb_state_t S_WAIT  = 2'd2;
  localparam arb_state_t S_DONE  = 2'd3;
endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: picks the first active request at or after last_i+1, wrapping
module rr_priority_encoder import tinyalu_pkg::*; (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [1:0]         idx_o,
  output logic               valid_o
);
  // scan from the farthest offset down so the nearest offset after last_i wins
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_i[last_i + 2'(i)]) idx_o = last_i + 2'(i);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbitration of four requesters onto one SRAM port with timeout
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = tinyalu_pkg::ARB_TIMEOUT
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic [NUM_REQ-1:0]                                    proc_req,
  input  logic [NUM_REQ-1:0]                                    proc_re,
  input  logic [NUM_REQ-1:0]                                    proc_we,
  input  logic [NUM_REQ-1:0][tinyalu_pkg::MEM_ADDR_W-1:0]       proc_addr,
  input  logic [NUM_REQ-1:0][tinyalu_pkg::MEM_WDATA_W-1:0]      proc_wdata,
  output logic [NUM_REQ-1:0]                                    proc_resp,
  output logic [tinyalu_pkg::MEM_RDATA_W-1:0]                   proc_rdata,
  output logic                                                  proc_err,
  output logic [1:0]                                            grant_id,
  output logic                                                  sram_re,
  output logic                                                  sram_we,
  output logic [tinyalu_pkg::MEM_ADDR_W-1:0]                    sram_addr,
  output logic [tinyalu_pkg::MEM_WDATA_W-1:0]                   sram_wdata,
  input  logic [tinyalu_pkg::MEM_RDATA_W-1:0]                   sram_rdata,
  input  logic                                                  sram_resp
);
  import tinyalu_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t             state_q, state_d;
  logic [1:0]             grant_q, grant_d, last_q, last_d, pick;
  logic                   pick_v, re_q, re_d, we_q, we_d, err_q, err_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
  logic [MEM_WDATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_RDATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy;

  rr_priority_encoder u_rr (
    .req_i   (proc_req),
    .last_i  (last_q),
    .idx_o   (pick),
    .valid_o (pick_v)
  );

  // next-state: arbitrate in IDLE, strobe in ISSUE, wait for response or timeout, report in DONE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re_d    = re_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (pick_v) begin
        state_d = S_ISSUE;
        grant_d = pick;
        addr_d  = proc_addr[pick];
        wdata_d = proc_wdata[pick];
        re_d    = proc_re[pick];
        we_d    = proc_we[pick];
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = (re_q == we_q) ? S_DONE : S_WAIT;
        err_d   = (re_q == we_q) ? 1'b1 : err_q;
        rdata_d = (re_q == we_q) ? '0 : rdata_q;
      end
      S_WAIT: if (sram_resp) begin
        state_d = S_DONE;
        rdata_d = we_q ? '0 : sram_rdata;
        err_d   = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = S_DONE;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: begin
        state_d = S_IDLE;
        last_d  = grant_q;
      end
    endcase
  end

  // state registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign sram_re    = (state_q == S_ISSUE) && re_q && !we_q;
  assign sram_we    = (state_q == S_ISSUE) && we_q && !re_q;
  assign sram_addr  = busy ? addr_q : '0;
  assign sram_wdata = busy ? wdata_q : '0;
  assign proc_resp  = (state_q == S_DONE) ? NUM_REQ'(1) << grant_q : '0;
  assign grant_id   = (state_q == S_IDLE) ? 2'd0 : grant_q;
  assign proc_rdata = rdata_q;
  assign proc_err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench for the round-robin SRAM arbiter
module tb_mem_arbiter;
  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        proc_req, proc_re, proc_we, proc_resp;
  logic [3:0][13:0]  proc_addr;
  logic [3:0][15:0]  proc_wdata;
  logic [7:0]        proc_rdata, sram_rdata;
  logic              proc_err, sram_re, sram_we, sram_resp;
  logic [1:0]        grant_id;
  logic [13:0]       sram_addr;
  logic [15:0]       sram_wdata;
  int                checks = 0;
  int                failures = 0;

  typedef struct {
    int         idx;
    logic       re;
    logic       we;
    logic [13:0] addr;
    logic [15:0] wdata;
    int         resp_at;
    logic [7:0] srdata;
    logic [1:0] strobe;
    int         resp_cyc;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  vec_t vt[7];
  logic [3:0] exp_f[5];

  mem_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .proc_req(proc_req), .proc_re(proc_re), .proc_we(proc_we),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_resp(proc_resp), .proc_rdata(proc_rdata), .proc_err(proc_err),
    .grant_id(grant_id), .sram_re(sram_re), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_resp(sram_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_strobe"}, {sram_we, sram_re}, 0);
    chk({name, "_addr"}, sram_addr, 0);
    chk({name, "_wdata"}, sram_wdata, 0);
    chk({name, "_resp"}, proc_resp, 0);
    chk({name, "_rdata"}, proc_rdata, 0);
    chk({name, "_err"}, proc_err, 0);
    chk({name, "_gnt"}, grant_id, 0);
  endtask

  task automatic clear_inputs();
    proc_req = '0; proc_re = '0; proc_we = '0;
    proc_addr = '0; proc_wdata = '0;
    sram_resp = 1'b0; sram_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    clear_inputs();
    @(negedge clk);
    proc_req[v.idx] = 1'b1;
    proc_re[v.idx] = v.re;
    proc_we[v.idx] = v.we;
    proc_addr[v.idx] = v.addr;
    proc_wdata[v.idx] = v.wdata;
    for (int c = 1; c <= v.resp_cyc + 1; c++) begin
      @(negedge clk);
      proc_req = '0;
      sram_resp = 1'b0;
      chk("strobe", {sram_we, sram_re}, c == 1 ? v.strobe : 2'b00);
      chk("resp", proc_resp, c == v.resp_cyc ? 4'b0001 << v.idx : 4'b0000);
      if (c == 1) chk("gnt_issue", grant_id, v.idx);
      if (c < v.resp_cyc && v.strobe != 2'b00) begin
        chk("hold_addr", sram_addr, v.addr);
        chk("hold_wdata", sram_wdata, v.wdata);
      end
      if (c == v.resp_cyc) chk("gnt_done", grant_id, v.idx);
      if (c >= v.resp_cyc) begin
        chk("rdata", proc_rdata, v.rdata);
        chk("err", proc_err, v.err);
      end
      if (c == v.resp_at) begin
        sram_resp = 1'b1;
        sram_rdata = v.srdata;
      end
    end
    sram_resp = 1'b0;
  endtask

  initial begin
    int k;
    logic [3:0] prev;
    vt[0] = '{2, 1'b1, 1'b0, 14'h0123, 16'h0000, 2,  8'hA5, 2'b01, 3,  8'hA5, 1'b0};
    vt[1] = '{1, 1'b0, 1'b1, 14'h3FFF, 16'hBEEF, 4,  8'h77, 2'b10, 5,  8'h00, 1'b0};
    vt[2] = '{0, 1'b1, 1'b0, 14'h0055, 16'h1234, 0,  8'hEE, 2'b01, 18, 8'h00, 1'b1};
    vt[3] = '{3, 1'b1, 1'b1, 14'h0AAA, 16'h5555, 0,  8'hEE, 2'b00, 2,  8'h00, 1'b1};
    vt[4] = '{0, 1'b1, 1'b0, 14'h1000, 16'h0000, 17, 8'h3C, 2'b01, 18, 8'h3C, 1'b0};
    vt[5] = '{2, 1'b0, 1'b0, 14'h0001, 16'h0002, 0,  8'hEE, 2'b00, 2,  8'h00, 1'b1};
    vt[6] = '{1, 1'b1, 1'b0, 14'h2222, 16'h0000, 3,  8'h81, 2'b01, 4,  8'h81, 1'b0};
    exp_f = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle");

    proc_req = 4'hF; proc_re = 4'hF;
    sram_resp = 1'b1; sram_rdata = 8'h11;
    k = 0;
    prev = '0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clk);
      if (proc_resp != 4'b0000) begin
        chk("fair_grant", proc_resp, exp_f[k]);
        chk("fair_pulse", prev, 0);
        k++;
        if (k == 5) proc_req = '0;
      end
      prev = proc_resp;
    end
    chk("fair_count", k, 5);
    clear_inputs();
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i]);

    sram_resp = 1'b1; sram_rdata = 8'hCC;
    repeat (2) begin
      @(negedge clk);
      chk("idle_resp_ignored", proc_resp, 0);
      chk("idle_rdata_hold", proc_rdata, 8'h81);
    end
    sram_resp = 1'b0;

    @(negedge clk);
    proc_req[2] = 1'b1; proc_re[2] = 1'b1; proc_addr[2] = 14'h0222;
    @(negedge clk);
    proc_req = '0;
    @(negedge clk);
    chk("mid_wait_addr", sram_addr, 14'h0222);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    #1 reset_n = 1'b1;
    @(negedge clk);
    sram_resp = 1'b1; sram_rdata = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      sram_resp = 1'b0;
      chk("late_resp_ignored", proc_resp, 0);
      chk("late_rdata", proc_rdata, 0);
    end
    run_vec('{0, 1'b1, 1'b0, 14'h0042, 16'h0000, 2, 8'h5A, 2'b01, 3, 8'h5A, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of cycles to wait for the SRAM response.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port proc_req  input  [3:0]  per-requester chip select from a memory interface cs.
REQ-006 SHALL have port proc_re  input  [3:0]  per-requester read request.
REQ-007 SHALL have port proc_we  input  [3:0]  per-requester write request.
REQ-008 SHALL have port proc_addr  input  4x[13:0]  per-requester address.
REQ-009 SHALL have port proc_wdata  input  4x[15:0]  per-requester write data.
REQ-010 SHALL have port proc_resp  output  [3:0]  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port proc_rdata  output  [7:0]  read data, shared across requesters, valid with proc_resp.
REQ-012 SHALL have port proc_err  output  1  error flag, valid with proc_resp.
REQ-013 SHALL have port grant_id  output  [1:0]  index of the requester currently being served.
REQ-014 SHALL have ports sram_re/sram_we  output  1 each  SRAM strobes.
REQ-015 SHALL have ports sram_addr  output  [13:0]  and sram_wdata  output  [15:0]  SRAM address and write data.
REQ-016 SHALL have ports sram_rdata  input  [7:0]  and sram_resp  input  1  SRAM read data and completion.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE, any proc_req high: SHALL pick the first requester at or after last_grant+1 (mod 4).
- On that pick it SHALL latch the index, addr, wdata, re and we, then go to ISSUE.
REQ-019 IDLE with no proc_req high: SHALL stay in IDLE with all outputs low.
REQ-020 ISSUE: SHALL assert exactly one of sram_re/sram_we for one cycle, then go to WAIT.
REQ-021 ISSUE with latched re==we (both high or both low): SHALL assert no SRAM strobe, go straight to DONE, and set proc_err=1.
REQ-022 WAIT: sram_addr and sram_wdata SHALL hold the latched values.
- On sram_resp=1 it SHALL register sram_rdata and go to DONE.
REQ-023 WAIT: a cycle counter SHALL start at 0 on entry.
- If it reaches TIMEOUT-1 without sram_resp, SHALL go to DONE with proc_err=1 and proc_rdata=0.
REQ-024 DONE: proc_resp[grant] SHALL be 1 for exactly one cycle, with last_grant<=grant, then go to IDLE.
REQ-025 SHALL ignore requests in ISSUE, WAIT and DONE; a requester keeping proc_req high is re-arbitrated in IDLE behind the others.
REQ-026 Best-case latency: proc_req sampled at cycle 0, strobe at cycle 1, sram_resp at cycle 2, proc_resp at cycle 3.
REQ-027 sram_resp arriving outside WAIT SHALL be ignored.
REQ-028 proc_rdata SHALL be 0 after a write.
REQ-029 proc_rdata and proc_err SHALL hold until the next DONE.

Reset
REQ-030 reset_n low SHALL force, asynchronously, state=IDLE, last_grant=3, counter=0.
- Same reset: all outputs 0, including grant_id, proc_rdata and proc_err.
REQ-031 Reset during ISSUE/WAIT SHALL abandon the transfer with no proc_resp issued; a late sram_resp SHALL be ignored.

Structure
REQ-032 tinyalu_pkg SHALL hold arb_state_t, NUM_REQ, MEM_ADDR_W=14, MEM_WDATA_W=16, MEM_RDATA_W=8 and ARB_TIMEOUT.
REQ-033 Round-robin selection SHALL live in a combinational sub-module, rr_priority_encoder (request vector and last grant in, index and valid out).

Verification
REQ-034 Single read: req[2], re, addr=0x0123; sram_resp at cycle 2 with rdata=0xA5 -> sram_re cycle 1, proc_resp=4'b0100 cycle 3, rdata=0xA5, err=0.
REQ-035 Fairness: req=4'b1111 held after reset -> grants in order 0,1,2,3,0; each proc_resp one cycle.
REQ-036 Write: req[1], we, addr=0x3FFF, wdata=0xBEEF -> sram_we one cycle, sram_addr=0x3FFF, sram_wdata=0xBEEF held through WAIT, rdata=0.
REQ-037 Timeout: read with sram_resp never asserted -> proc_resp after TIMEOUT wait cycles, err=1, rdata=0.
REQ-038 Illegal op: req[3] with re=we=1 -> no SRAM strobe, proc_resp[3] at cycle 2, err=1.
REQ-039 Reset mid-WAIT: reset_n pulsed low, then sram_resp -> no proc_resp; the next req=4'b0001 is granted to requester 0.
